i2c_reg_sequencer: RTL and testbench

// Register-access transaction engine in front of the i2c_master AXI-Stream core.

---
 rtl/i2c_reg_sequencer.sv | 267 ++++++++++++++++++++++++++
 tb/tb_i2c_reg_sequencer.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_reg_sequencer.sv
// Register-access sequencer in front of the i2c_master AXI-Stream core. It turns one request into the command/TX/RX stream sequence.
// Optional stall watchdog: define I2C_SEQ_TIMEOUT_EN.
module i2c_reg_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 200000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_read,
  input  logic [6:0]  req_dev_addr,
  input  logic [7:0]  req_reg_addr,
  input  logic [1:0]  req_len,
  input  logic [31:0] req_wdata,
  output logic        done,
  output logic [31:0] rdata,
  output logic        err_nack,
  output logic        err_timeout,
  output logic        busy,
  output logic [6:0]  m_cmd_address,
  output logic        m_cmd_start,
  output logic        m_cmd_read,
  output logic        m_cmd_write,
  output logic        m_cmd_write_multiple,
  output logic        m_cmd_stop,
  output logic        m_cmd_valid,
  input  logic        m_cmd_ready,
  output logic [7:0]  m_tx_tdata,
  output logic        m_tx_tvalid,
  output logic        m_tx_tlast,
  input  logic        m_tx_tready,
  input  logic [7:0]  s_rx_tdata,
  input  logic        s_rx_tvalid,
  output logic        s_rx_tready,
  input  logic        i2c_busy,
  input  logic        i2c_missed_ack
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] CMD_ADDR  = 3'd1;
  localparam logic [2:0] TX_REG    = 3'd2;
  localparam logic [2:0] TX_DATA   = 3'd3;
  localparam logic [2:0] RD_CMD    = 3'd4;
  localparam logic [2:0] RD_DATA   = 3'd5;
  localparam logic [2:0] WAIT_IDLE = 3'd6;
  localparam logic [2:0] DONE      = 3'd7;

  logic [2:0]  state_q, state_d;
  logic        read_q, read_d;
  logic [6:0]  dev_q, dev_d;
  logic [7:0]  reg_q, reg_d;
  logic [1:0]  len_q, len_d;
  logic [31:0] wdata_q, wdata_d;
  logic [1:0]  idx_q, idx_d;
  logic        arm_q, arm_d;
  logic [31:0] rdata_q, rdata_d;
  logic        nack_q, nack_d;
  logic        done_q, done_d;
  logic        busy_q, busy_d;
  logic [6:0]  cmd_addr_q, cmd_addr_d;
  logic        cmd_start_q, cmd_start_d;
  logic        cmd_read_q, cmd_read_d;
  logic        cmd_wm_q, cmd_wm_d;
  logic        cmd_stop_q, cmd_stop_d;
  logic        cmd_valid_q, cmd_valid_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_valid_q, tx_valid_d;
  logic        tx_last_q, tx_last_d;
  logic        rx_ready_q, rx_ready_d;

  logic accept, cmd_fire, tx_fire, rx_fire;

`ifdef I2C_SEQ_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_q, tmo_d;
  logic          err_tmo_q, err_tmo_d;
  logic          hs;
`else
  logic unused_cfg;
  assign unused_cfg = ^32'(TIMEOUT_CYCLES);
`endif

  assign req_ready = (state_q == IDLE) && !i2c_busy && !rst;
  assign accept    = req_valid && req_ready;
  assign cmd_fire  = cmd_valid_q && m_cmd_ready;
  assign tx_fire   = tx_valid_q && m_tx_tready;
  assign rx_fire   = rx_ready_q && s_rx_tvalid;

  // Next state plus all registered outputs, derived from the next state so valids and payload move together.
  always_comb begin
    state_d = state_q;
    read_d  = read_q;
    dev_d   = dev_q;
    reg_d   = reg_q;
    len_d   = len_q;
    wdata_d = wdata_q;
    idx_d   = idx_q;
    rdata_d = rdata_q;
    nack_d  = nack_q;
    arm_d   = (state_q == WAIT_IDLE);
`ifdef I2C_SEQ_TIMEOUT_EN
    err_tmo_d = err_tmo_q;
    hs        = cmd_fire || tx_fire || rx_fire;
`endif

    if (state_q != IDLE && i2c_missed_ack) nack_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (accept) begin
          read_d  = req_read;
          dev_d   = req_dev_addr;
          reg_d   = req_reg_addr;
          len_d   = req_len;
          wdata_d = req_wdata;
          idx_d   = 2'd0;
          rdata_d = 32'd0;
          nack_d  = 1'b0;
`ifdef I2C_SEQ_TIMEOUT_EN
          err_tmo_d = 1'b0;
`endif
          state_d = CMD_ADDR;
        end
      end
      CMD_ADDR: if (cmd_fire) state_d = TX_REG;
      TX_REG: begin
        if (tx_fire) begin
          idx_d   = 2'd0;
          state_d = read_q ? RD_CMD : TX_DATA;
        end
      end
      TX_DATA: begin
        if (tx_fire) begin
          if (idx_q == len_q) state_d = WAIT_IDLE;
          else                idx_d   = idx_q + 2'd1;
        end
      end
      RD_CMD: if (cmd_fire) state_d = RD_DATA;
      RD_DATA: begin
        if (rx_fire) begin
          rdata_d[{idx_q, 3'b000} +: 8] = s_rx_tdata;
          if (idx_q == len_q) begin
            state_d = WAIT_IDLE;
          end else begin
            idx_d   = idx_q + 2'd1;
            state_d = RD_CMD;
          end
        end
      end
      // The entry cycle is skipped so the master has time to raise busy.
      WAIT_IDLE: if (arm_q && !i2c_busy) state_d = DONE;
      DONE:      state_d = IDLE;
      default:   state_d = IDLE;
    endcase

`ifdef I2C_SEQ_TIMEOUT_EN
    if (accept || hs || state_q == IDLE) tmo_d = '0;
    else                                 tmo_d = tmo_q + TW'(1);
    if (state_q != IDLE && state_q != DONE && !hs && tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
      state_d   = DONE;
      err_tmo_d = 1'b1;
    end
`endif

    cmd_valid_d = (state_d == CMD_ADDR) || (state_d == RD_CMD);
    cmd_addr_d  = cmd_valid_d ? dev_d : 7'd0;
    cmd_start_d = (state_d == CMD_ADDR) || (state_d == RD_CMD && idx_d == 2'd0);
    cmd_wm_d    = (state_d == CMD_ADDR);
    cmd_read_d  = (state_d == RD_CMD);
    cmd_stop_d  = (state_d == CMD_ADDR && !read_d) || (state_d == RD_CMD && idx_d == len_d);
    tx_valid_d  = (state_d == TX_REG) || (state_d == TX_DATA);
    tx_data_d   = 8'd0;
    tx_last_d   = 1'b0;
    if (state_d == TX_REG) begin
      tx_data_d = reg_d;
      tx_last_d = read_d;
    end else if (state_d == TX_DATA) begin
      tx_data_d = wdata_d[{idx_d, 3'b000} +: 8];
      tx_last_d = (idx_d == len_d);
    end
    rx_ready_d = (state_d == RD_DATA);
    done_d     = (state_d == DONE);
    busy_d     = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      read_q      <= 1'b0;
      dev_q       <= 7'd0;
      reg_q       <= 8'd0;
      len_q       <= 2'd0;
      wdata_q     <= 32'd0;
      idx_q       <= 2'd0;
      arm_q       <= 1'b0;
      rdata_q     <= 32'd0;
      nack_q      <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      cmd_addr_q  <= 7'd0;
      cmd_start_q <= 1'b0;
      cmd_read_q  <= 1'b0;
      cmd_wm_q    <= 1'b0;
      cmd_stop_q  <= 1'b0;
      cmd_valid_q <= 1'b0;
      tx_data_q   <= 8'd0;
      tx_valid_q  <= 1'b0;
      tx_last_q   <= 1'b0;
      rx_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      read_q      <= read_d;
      dev_q       <= dev_d;
      reg_q       <= reg_d;
      len_q       <= len_d;
      wdata_q     <= wdata_d;
      idx_q       <= idx_d;
      arm_q       <= arm_d;
      rdata_q     <= rdata_d;
      nack_q      <= nack_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_start_q <= cmd_start_d;
      cmd_read_q  <= cmd_read_d;
      cmd_wm_q    <= cmd_wm_d;
      cmd_stop_q  <= cmd_stop_d;
      cmd_valid_q <= cmd_valid_d;
      tx_data_q   <= tx_data_d;
      tx_valid_q  <= tx_valid_d;
      tx_last_q   <= tx_last_d;
      rx_ready_q  <= rx_ready_d;
    end
  end

`ifdef I2C_SEQ_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_q     <= '0;
      err_tmo_q <= 1'b0;
    end else begin
      tmo_q     <= tmo_d;
      err_tmo_q <= err_tmo_d;
    end
  end
  assign err_timeout = err_tmo_q;
`else
  assign err_timeout = 1'b0;
`endif

  assign done                 = done_q;
  assign rdata                = rdata_q;
  assign err_nack             = nack_q;
  assign busy                 = busy_q;
  assign m_cmd_address        = cmd_addr_q;
  assign m_cmd_start          = cmd_start_q;
  assign m_cmd_read           = cmd_read_q;
  assign m_cmd_write          = 1'b0;
  assign m_cmd_write_multiple = cmd_wm_q;
  assign m_cmd_stop           = cmd_stop_q;
  assign m_cmd_valid          = cmd_valid_q;
  assign m_tx_tdata           = tx_data_q;
  assign m_tx_tvalid          = tx_valid_q;
  assign m_tx_tlast           = tx_last_q;
  assign s_rx_tready          = rx_ready_q;

endmodule

// File: tb/tb_i2c_reg_sequencer.sv
// Directed bench for i2c_reg_sequencer with a small behavioural i2c_master responder.
module tb_i2c_reg_sequencer;
  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_read;
  logic [6:0]  req_dev_addr;
  logic [7:0]  req_reg_addr;
  logic [1:0]  req_len;
  logic [31:0] req_wdata;
  logic        done, err_nack, err_timeout, busy;
  logic [31:0] rdata;
  logic [6:0]  m_cmd_address;
  logic        m_cmd_start, m_cmd_read, m_cmd_write, m_cmd_write_multiple, m_cmd_stop;
  logic        m_cmd_valid, m_cmd_ready;
  logic [7:0]  m_tx_tdata;
  logic        m_tx_tvalid, m_tx_tlast, m_tx_tready;
  logic [7:0]  s_rx_tdata;
  logic        s_rx_tvalid, s_rx_tready;
  logic        i2c_busy, i2c_missed_ack;

  always #5 clk = ~clk;

  i2c_reg_sequencer #(.TIMEOUT_CYCLES(100)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_read(req_read),
    .req_dev_addr(req_dev_addr), .req_reg_addr(req_reg_addr), .req_len(req_len),
    .req_wdata(req_wdata), .done(done), .rdata(rdata), .err_nack(err_nack),
    .err_timeout(err_timeout), .busy(busy),
    .m_cmd_address(m_cmd_address), .m_cmd_start(m_cmd_start), .m_cmd_read(m_cmd_read),
    .m_cmd_write(m_cmd_write), .m_cmd_write_multiple(m_cmd_write_multiple),
    .m_cmd_stop(m_cmd_stop), .m_cmd_valid(m_cmd_valid), .m_cmd_ready(m_cmd_ready),
    .m_tx_tdata(m_tx_tdata), .m_tx_tvalid(m_tx_tvalid), .m_tx_tlast(m_tx_tlast),
    .m_tx_tready(m_tx_tready), .s_rx_tdata(s_rx_tdata), .s_rx_tvalid(s_rx_tvalid),
    .s_rx_tready(s_rx_tready), .i2c_busy(i2c_busy), .i2c_missed_ack(i2c_missed_ack)
  );

  int n_vec = 0;
  int n_bad = 0;
  logic [11:0] cmd_log[$];
  logic [8:0]  tx_log[$];
  logic [7:0]  rx_q[$];
  bit stall_tx = 1'b0;
  bit nack_arm = 1'b0;
  int busy_cnt = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // {addr, start, read, write, write_multiple, stop}
  function automatic logic [11:0] cw(input logic [6:0] a, input logic s, input logic r,
                                     input logic wm, input logic p);
    return {a, s, r, 1'b0, wm, p};
  endfunction

  function automatic logic [11:0] cmd_at(input int i);
    return (i < cmd_log.size()) ? cmd_log[i] : 12'hFFF;
  endfunction

  function automatic logic [8:0] tx_at(input int i);
    return (i < tx_log.size()) ? tx_log[i] : 9'h1FF;
  endfunction

  // Master model: handshakes are sampled mid-cycle and take effect just after the next rising edge.
  initial begin
    bit fc, ft, fr;
    logic [11:0] cw_s;
    logic [8:0]  tw_s;
    forever begin
      @(negedge clk); #1;
      fc   = m_cmd_valid && m_cmd_ready;
      cw_s = {m_cmd_address, m_cmd_start, m_cmd_read, m_cmd_write, m_cmd_write_multiple, m_cmd_stop};
      ft   = m_tx_tvalid && m_tx_tready;
      tw_s = {m_tx_tlast, m_tx_tdata};
      fr   = s_rx_tvalid && s_rx_tready;
      @(posedge clk); #1;
      if (rst) begin
        busy_cnt       = 0;
        i2c_missed_ack = 1'b0;
      end else begin
        if (fc) cmd_log.push_back(cw_s);
        if (ft) tx_log.push_back(tw_s);
        if (fr && rx_q.size() > 0) void'(rx_q.pop_front());
        i2c_missed_ack = fc && nack_arm;
        if (fc) nack_arm = 1'b0;
        if (fc || ft || fr) busy_cnt = 3;
        else if (busy_cnt > 0) busy_cnt--;
      end
      i2c_busy    = (busy_cnt > 0);
      m_tx_tready = !stall_tx;
      s_rx_tvalid = (rx_q.size() > 0);
      s_rx_tdata  = (rx_q.size() > 0) ? rx_q[0] : 8'h00;
    end
  end

  task automatic issue_req(input logic rd, input logic [6:0] dev, input logic [7:0] ra,
                           input logic [1:0] len, input logic [31:0] wd, input string tag);
    bit rdy;
    cmd_log.delete();
    tx_log.delete();
    rdy = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (req_ready) begin
        rdy = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check_eq({tag, "_ready"}, 32'(rdy), 32'd1);
    req_valid    = 1'b1;
    req_read     = rd;
    req_dev_addr = dev;
    req_reg_addr = ra;
    req_len      = len;
    req_wdata    = wd;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check_eq({tag, "_done"}, 32'(seen), 32'd1);
  endtask

  task automatic check_pulse_end(input string tag);
    @(negedge clk);
    check_eq({tag, "_pulse"}, {30'd0, done, busy}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_read = 1'b0; req_dev_addr = '0; req_reg_addr = '0;
    req_len = '0; req_wdata = '0; m_cmd_ready = 1'b1; m_tx_tready = 1'b1;
    s_rx_tvalid = 1'b0; s_rx_tdata = '0; i2c_busy = 1'b0; i2c_missed_ack = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check_eq("rst_ready", 32'(req_ready), 32'd0);
    check_eq("rst_flags", {25'd0, done, busy, err_nack, err_timeout, m_cmd_valid, m_tx_tvalid, s_rx_tready}, 32'd0);
    check_eq("rst_rdata", rdata, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("idle_ready", 32'(req_ready), 32'd1);

    // Write dev 0x50 reg 0x10, two bytes
    issue_req(1'b0, 7'h50, 8'h10, 2'd1, 32'h0000BEEF, "wr2");
    wait_done("wr2", 1000);
    check_eq("wr2_err", {30'd0, err_nack, err_timeout}, 32'd0);
    check_eq("wr2_ncmd", 32'(cmd_log.size()), 32'd1);
    check_eq("wr2_cmd0", 32'(cmd_at(0)), 32'(cw(7'h50, 1'b1, 1'b0, 1'b1, 1'b1)));
    check_eq("wr2_ntx", 32'(tx_log.size()), 32'd3);
    check_eq("wr2_tx0", 32'(tx_at(0)), 32'h010);
    check_eq("wr2_tx1", 32'(tx_at(1)), 32'h0EF);
    check_eq("wr2_tx2", 32'(tx_at(2)), 32'h1BE);
    check_pulse_end("wr2");

    // Single-byte read with repeated start
    rx_q.push_back(8'h71);
    issue_req(1'b1, 7'h68, 8'h75, 2'd0, 32'd0, "rd1");
    wait_done("rd1", 1000);
    check_eq("rd1_rdata", rdata, 32'h00000071);
    check_eq("rd1_ntx", 32'(tx_log.size()), 32'd1);
    check_eq("rd1_tx0", 32'(tx_at(0)), 32'h175);
    check_eq("rd1_ncmd", 32'(cmd_log.size()), 32'd2);
    check_eq("rd1_cmd0", 32'(cmd_at(0)), 32'(cw(7'h68, 1'b1, 1'b0, 1'b1, 1'b0)));
    check_eq("rd1_cmd1", 32'(cmd_at(1)), 32'(cw(7'h68, 1'b1, 1'b1, 1'b0, 1'b1)));
    check_pulse_end("rd1");

    // Four-byte read: start only on first read command, stop only on last
    rx_q.push_back(8'h11); rx_q.push_back(8'h22); rx_q.push_back(8'h33); rx_q.push_back(8'h44);
    issue_req(1'b1, 7'h3C, 8'h00, 2'd3, 32'd0, "rd4");
    wait_done("rd4", 1000);
    check_eq("rd4_rdata", rdata, 32'h44332211);
    check_eq("rd4_ncmd", 32'(cmd_log.size()), 32'd5);
    check_eq("rd4_cmd1", 32'(cmd_at(1)), 32'(cw(7'h3C, 1'b1, 1'b1, 1'b0, 1'b0)));
    check_eq("rd4_cmd2", 32'(cmd_at(2)), 32'(cw(7'h3C, 1'b0, 1'b1, 1'b0, 1'b0)));
    check_eq("rd4_cmd3", 32'(cmd_at(3)), 32'(cw(7'h3C, 1'b0, 1'b1, 1'b0, 1'b0)));
    check_eq("rd4_cmd4", 32'(cmd_at(4)), 32'(cw(7'h3C, 1'b0, 1'b1, 1'b0, 1'b1)));
    check_eq("rd4_rxleft", 32'(rx_q.size()), 32'd0);
    check_pulse_end("rd4");

    // NACK after address: bytes still go out, flag sticky, rdata cleared on accept
    nack_arm = 1'b1;
    issue_req(1'b0, 7'h20, 8'h01, 2'd1, 32'h00005AA5, "nak");
    wait_done("nak", 1000);
    check_eq("nak_err", 32'(err_nack), 32'd1);
    check_eq("nak_ntx", 32'(tx_log.size()), 32'd3);
    check_eq("nak_tx2", 32'(tx_at(2)), 32'h15A);
    check_eq("nak_rdata", rdata, 32'd0);
    check_pulse_end("nak");
    check_eq("nak_sticky", 32'(err_nack), 32'd1);
    issue_req(1'b0, 7'h20, 8'h02, 2'd0, 32'h000000C3, "clr");
    check_eq("clr_err", 32'(err_nack), 32'd0);
    wait_done("clr", 1000);
    check_eq("clr_tx1", 32'(tx_at(1)), 32'h1C3);
    check_pulse_end("clr");

    // TX stall
    stall_tx = 1'b1;
    issue_req(1'b0, 7'h11, 8'h22, 2'd0, 32'h00000033, "stl");
`ifdef I2C_SEQ_TIMEOUT_EN
    wait_done("stl", 300);
    check_eq("stl_tmo", 32'(err_timeout), 32'd1);
    check_eq("stl_valids", {30'd0, m_cmd_valid, m_tx_tvalid}, 32'd0);
    stall_tx = 1'b0;
    check_pulse_end("stl");
`else
    repeat (300) @(negedge clk);
    check_eq("stl_hold", {29'd0, busy, m_tx_tvalid, err_timeout}, 32'd6);
    check_eq("stl_tdata", 32'(m_tx_tdata), 32'h22);
    stall_tx = 1'b0;
    wait_done("stl", 1000);
    check_eq("stl_ntx", 32'(tx_log.size()), 32'd2);
    check_pulse_end("stl");
`endif

    // Reset in the middle of the data phase
    issue_req(1'b0, 7'h2A, 8'h40, 2'd3, 32'hDDCCBBAA, "mrs");
    begin
      bit hit;
      hit = 1'b0;
      for (int i = 0; i < 50; i++) begin
        if (tx_log.size() >= 1 && m_tx_tvalid) begin
          hit = 1'b1;
          break;
        end
        @(negedge clk);
      end
      check_eq("mrs_txdata", 32'(hit), 32'd1);
    end
    rst = 1'b1;
    @(negedge clk);
    check_eq("mrs_flags", {28'd0, busy, done, m_cmd_valid, m_tx_tvalid}, 32'd0);
    check_eq("mrs_rdata", rdata, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("mrs_ready", 32'(req_ready), 32'd1);

    // Recovery: two-byte read
    rx_q.push_back(8'hAA); rx_q.push_back(8'hBB);
    issue_req(1'b1, 7'h68, 8'h01, 2'd1, 32'd0, "rcv");
    wait_done("rcv", 1000);
    check_eq("rcv_rdata", rdata, 32'h0000BBAA);
    check_eq("rcv_ncmd", 32'(cmd_log.size()), 32'd3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
